dsp_filter_scheduler: RTL and testbench

DSP_FILTER_SCHEDULER -- requirements
Module: dsp_filter_scheduler

---
 rtl/audioport_pkg.sv | 28 ++
 rtl/dsp_filter_scheduler_if.sv | 27 ++
 rtl/dsp_mac.sv | 45 ++++
 rtl/dsp_filter_scheduler.sv | 176 +++++++++++++++++
 tb/tb_dsp_filter_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audioport_pkg.sv
// Shared constants, FSM state type and output saturation helper for the
// dual-channel FIR scheduler.
package audioport_pkg;

    localparam int DSP_REGISTERS = 8;
    localparam int FILTER_TAPS   = DSP_REGISTERS / 2;
    localparam int SAMPLE_W      = 24;
    localparam int FRAC_BITS     = 23;

    typedef enum logic [1:0] {
        IDLE,
        MAC0,
        MAC1,
        DONE
    } dsp_sched_state_t;

    // Clamp an already-rescaled sum into the signed 24-bit sample range.
    function automatic logic [SAMPLE_W-1:0] sat24(input logic signed [63:0] v);
        if (v > 64'sd8388607) begin
            return 24'h7FFFFF;
        end else if (v < -64'sd8388608) begin
            return 24'h800000;
        end else begin
            return v[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/dsp_filter_scheduler_if.sv
// Sample/coefficient/result bundle between the audio host and the FIR scheduler.
interface dsp_filter_scheduler_if;
    import audioport_pkg::*;

    logic                         play_in;
    logic                         tick_in;
    logic                         clr_in;
    logic [SAMPLE_W-1:0]          audio0_in;
    logic [SAMPLE_W-1:0]          audio1_in;
    logic [DSP_REGISTERS*32-1:0]  dsp_regs_in;
    logic [SAMPLE_W-1:0]          audio0_out;
    logic [SAMPLE_W-1:0]          audio1_out;
    logic                         valid_out;
    logic                         busy_out;
    logic                         overrun_out;

    modport master (
        output play_in, tick_in, clr_in, audio0_in, audio1_in, dsp_regs_in,
        input  audio0_out, audio1_out, valid_out, busy_out, overrun_out
    );

    modport slave (
        input  play_in, tick_in, clr_in, audio0_in, audio1_in, dsp_regs_in,
        output audio0_out, audio1_out, valid_out, busy_out, overrun_out
    );

endinterface

// File: rtl/dsp_mac.sv
// Single shared signed 24x24 multiplier feeding a wide accumulator.
module dsp_mac #(
    parameter int ACC_W = 51
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_in,
    input  logic                    en_in,
    input  logic signed [23:0]      a_in,
    input  logic signed [23:0]      b_in,
    output logic signed [ACC_W-1:0] sum_out
);

    logic signed [47:0]      a_ext;
    logic signed [47:0]      b_ext;
    logic signed [47:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    always_comb begin
        a_ext    = {{24{a_in[23]}}, a_in};
        b_ext    = {{24{b_in[23]}}, b_in};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_W-48){prod[47]}}, prod};
        // sum_out includes the current product so the last tap can be latched
        // on the same edge that clears the accumulator.
        sum_out  = acc_q + prod_ext;
        acc_d    = acc_q;
        if (clr_in) begin
            acc_d = '0;
        end else if (en_in) begin
            acc_d = sum_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/dsp_filter_scheduler.sv
// Two-channel FIR scheduler: one multiplier walks channel 0 then channel 1 taps
// per sample tick, then publishes saturated Q1.23 results.
module dsp_filter_scheduler #(
    parameter int FILTER_TAPS = audioport_pkg::FILTER_TAPS
) (
    input  logic                   clk,
    input  logic                   rst,
    dsp_filter_scheduler_if.slave  bus
);
    import audioport_pkg::*;

    localparam int TAP_W = (FILTER_TAPS > 1) ? $clog2(FILTER_TAPS) : 1;
    localparam int ACC_W = 48 + $clog2(FILTER_TAPS) + 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(FILTER_TAPS - 1);

    logic signed [23:0] coef0 [FILTER_TAPS];
    logic signed [23:0] coef1 [FILTER_TAPS];
    logic [8*DSP_REGISTERS-1:0] unused_coef_hi;

    generate
        for (genvar gi = 0; gi < FILTER_TAPS; gi++) begin : g_coef
            assign coef0[gi] = bus.dsp_regs_in[gi*32 +: 24];
            assign coef1[gi] = bus.dsp_regs_in[(FILTER_TAPS+gi)*32 +: 24];
        end
        for (genvar gi = 0; gi < DSP_REGISTERS; gi++) begin : g_hi
            assign unused_coef_hi[gi*8 +: 8] = bus.dsp_regs_in[gi*32+24 +: 8];
        end
    endgenerate

    dsp_sched_state_t   state_q, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic signed [23:0] hist0_q [FILTER_TAPS];
    logic signed [23:0] hist0_d [FILTER_TAPS];
    logic signed [23:0] hist1_q [FILTER_TAPS];
    logic signed [23:0] hist1_d [FILTER_TAPS];
    logic signed [ACC_W-1:0] sum0_q, sum0_d, sum1_q, sum1_d;
    logic [23:0]        out0_q, out0_d, out1_q, out1_d;
    logic               valid_q, valid_d, overrun_q, overrun_d;

    logic                    mac_clr, mac_en;
    logic signed [23:0]      mac_a, mac_b;
    logic signed [ACC_W-1:0] mac_sum;
    logic signed [63:0]      ext0, ext1, sh0, sh1;

    dsp_mac #(.ACC_W(ACC_W)) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr_in  (mac_clr),
        .en_in   (mac_en),
        .a_in    (mac_a),
        .b_in    (mac_b),
        .sum_out (mac_sum)
    );

    assign ext0 = {{(64-ACC_W){sum0_q[ACC_W-1]}}, sum0_q};
    assign ext1 = {{(64-ACC_W){sum1_q[ACC_W-1]}}, sum1_q};
    assign sh0  = ext0 >>> FRAC_BITS;
    assign sh1  = ext1 >>> FRAC_BITS;

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        hist0_d   = hist0_q;
        hist1_d   = hist1_q;
        sum0_d    = sum0_q;
        sum1_d    = sum1_q;
        out0_d    = out0_q;
        out1_d    = out1_q;
        valid_d   = 1'b0;
        // Ticks landing mid-sequence are dropped and flagged; clear wins silently.
        overrun_d = bus.tick_in && bus.play_in && !bus.clr_in && (state_q != IDLE);
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        mac_a     = '0;
        mac_b     = '0;
        if (bus.clr_in) begin
            state_d = IDLE;
            tap_d   = '0;
            sum0_d  = '0;
            sum1_d  = '0;
            out0_d  = '0;
            out1_d  = '0;
            mac_clr = 1'b1;
            for (int i = 0; i < FILTER_TAPS; i++) begin
                hist0_d[i] = '0;
                hist1_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.tick_in && bus.play_in) begin
                        state_d    = MAC0;
                        tap_d      = '0;
                        mac_clr    = 1'b1;
                        hist0_d[0] = bus.audio0_in;
                        hist1_d[0] = bus.audio1_in;
                        for (int i = 1; i < FILTER_TAPS; i++) begin
                            hist0_d[i] = hist0_q[i-1];
                            hist1_d[i] = hist1_q[i-1];
                        end
                    end
                end
                MAC0: begin
                    mac_en = 1'b1;
                    mac_a  = coef0[tap_q];
                    mac_b  = hist0_q[tap_q];
                    if (tap_q == LAST_TAP) begin
                        sum0_d  = mac_sum;
                        mac_clr = 1'b1;
                        tap_d   = '0;
                        state_d = MAC1;
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
                MAC1: begin
                    mac_en = 1'b1;
                    mac_a  = coef1[tap_q];
                    mac_b  = hist1_q[tap_q];
                    if (tap_q == LAST_TAP) begin
                        sum1_d  = mac_sum;
                        mac_clr = 1'b1;
                        tap_d   = '0;
                        state_d = DONE;
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
                DONE: begin
                    out0_d  = sat24(sh0);
                    out1_d  = sat24(sh1);
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tap_q     <= '0;
            sum0_q    <= '0;
            sum1_q    <= '0;
            out0_q    <= '0;
            out1_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FILTER_TAPS; i++) begin
                hist0_q[i] <= '0;
                hist1_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            sum0_q    <= sum0_d;
            sum1_q    <= sum1_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < FILTER_TAPS; i++) begin
                hist0_q[i] <= hist0_d[i];
                hist1_q[i] <= hist1_d[i];
            end
        end
    end

    assign bus.audio0_out  = out0_q;
    assign bus.audio1_out  = out1_q;
    assign bus.valid_out   = valid_q;
    assign bus.overrun_out = overrun_q;
    assign bus.busy_out    = (state_q != IDLE);

endmodule

// File: tb/tb_dsp_filter_scheduler.sv
// Self-checking bench for dsp_filter_scheduler: table vectors, directed corner
// sequences and randomized traffic against a plain-arithmetic FIR model.
module tb_dsp_filter_scheduler;
    import audioport_pkg::*;

    localparam int T   = audioport_pkg::FILTER_TAPS;
    localparam int LAT = 2*T + 2;

    logic clk;
    logic rst;
    dsp_filter_scheduler_if bus_if ();

    dsp_filter_scheduler #(.FILTER_TAPS(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_seen = 0;
    int ovr_seen   = 0;

    logic [31:0] coef [DSP_REGISTERS];
    int          mh   [2][T];

    typedef struct {
        logic [31:0] c0;
        logic [31:0] c1;
        logic [23:0] a0;
        logic [23:0] a1;
        logic [23:0] e0;
        logic [23:0] e1;
    } vec_t;
    vec_t vecs [4];

    always @(posedge clk) begin
        #1;
        if (bus_if.valid_out)   valid_seen++;
        if (bus_if.overrun_out) ovr_seen++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_regs();
        for (int i = 0; i < DSP_REGISTERS; i++) bus_if.dsp_regs_in[i*32 +: 32] = coef[i];
    endtask

    task automatic model_clear();
        for (int j = 0; j < T; j++) begin
            mh[0][j] = 0;
            mh[1][j] = 0;
        end
    endtask

    task automatic model_push(input logic [23:0] a0, input logic [23:0] a1);
        for (int j = T - 1; j > 0; j--) begin
            mh[0][j] = mh[0][j-1];
            mh[1][j] = mh[1][j-1];
        end
        mh[0][0] = int'($signed(a0));
        mh[1][0] = int'($signed(a1));
    endtask

    // Direct FIR definition: sum of coef*sample, rescale, clamp.
    function automatic logic [23:0] model_out(input int ch);
        longint s;
        logic signed [23:0] c;
        s = 0;
        for (int j = 0; j < T; j++) begin
            c = coef[ch*T + j][23:0];
            s += longint'(c) * longint'(mh[ch][j]);
        end
        s = s >>> 23;
        if (s > 64'sd8388607) s = 64'sd8388607;
        else if (s < -64'sd8388608) s = -64'sd8388608;
        return s[23:0];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        bus_if.clr_in = 1'b1;
        @(negedge clk);
        bus_if.clr_in = 1'b0;
        model_clear();
    endtask

    task automatic send_tick(input logic [23:0] a0, input logic [23:0] a1);
        bus_if.audio0_in = a0;
        bus_if.audio1_in = a1;
        bus_if.tick_in   = 1'b1;
        if (bus_if.play_in) model_push(a0, a1);
        @(negedge clk);
        bus_if.tick_in = 1'b0;
    endtask

    // start_i: how many negedges have already passed since the tick was driven.
    task automatic wait_result(input string tag, input int start_i,
                               input logic [23:0] e0, input logic [23:0] e1);
        int lat;
        lat = -1;
        for (int i = start_i; i <= 60; i++) begin
            if (bus_if.valid_out) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_out0"}, bus_if.audio0_out, e0);
        check({tag, "_out1"}, bus_if.audio1_out, e1);
        $display("txn %s: lat=%0d out0=0x%06h out1=0x%06h exp0=0x%06h exp1=0x%06h",
                 tag, lat, bus_if.audio0_out, bus_if.audio1_out, e0, e1);
        @(negedge clk);
        check({tag, "_valid_one_cycle"}, bus_if.valid_out, 1'b0);
        check({tag, "_hold0"}, bus_if.audio0_out, e0);
    endtask

    task automatic set_coefs_zero();
        for (int i = 0; i < DSP_REGISTERS; i++) coef[i] = 32'h0;
    endtask

    initial begin
        int v0, o0, gap;
        logic [23:0] ra0, ra1;

        vecs[0] = '{c0: 32'h00400000, c1: 32'h00000000, a0: 24'h100000, a1: 24'h123456,
                    e0: 24'h080000, e1: 24'h000000};
        vecs[1] = '{c0: 32'hA57FFFFF, c1: 32'h5A400000, a0: 24'h200000, a1: 24'hFFFFF0,
                    e0: 24'h1FFFFF, e1: 24'hFFFFF8};
        vecs[2] = '{c0: 32'hFF800000, c1: 32'h00C00000, a0: 24'h800000, a1: 24'h000003,
                    e0: 24'h7FFFFF, e1: 24'hFFFFFE};
        vecs[3] = '{c0: 32'h01000001, c1: 32'h807FFFFF, a0: 24'h7FFFFF, a1: 24'h800000,
                    e0: 24'h000000, e1: 24'h800001};

        rst = 1'b1;
        bus_if.play_in   = 1'b1;
        bus_if.tick_in   = 1'b0;
        bus_if.clr_in    = 1'b0;
        bus_if.audio0_in = '0;
        bus_if.audio1_in = '0;
        set_coefs_zero();
        apply_regs();
        model_clear();
        step(3);
        check("rst_out0", bus_if.audio0_out, 24'h0);
        check("rst_out1", bus_if.audio1_out, 24'h0);
        check("rst_valid", bus_if.valid_out, 1'b0);
        check("rst_busy", bus_if.busy_out, 1'b0);
        check("rst_overrun", bus_if.overrun_out, 1'b0);
        rst = 1'b0;
        step(1);

        // Table vectors: history cleared first so only tap 0 contributes.
        for (int v = 0; v < 4; v++) begin
            set_coefs_zero();
            coef[0] = vecs[v].c0;
            coef[T] = vecs[v].c1;
            apply_regs();
            pulse_clr();
            send_tick(vecs[v].a0, vecs[v].a1);
            check($sformatf("vec%0d_busy", v), bus_if.busy_out, 1'b1);
            wait_result($sformatf("vec%0d", v), 1, vecs[v].e0, vecs[v].e1);
        end

        // Saturation across full channel-1 history.
        set_coefs_zero();
        for (int j = 0; j < T; j++) coef[T + j] = 32'h007FFFFF;
        apply_regs();
        pulse_clr();
        for (int k = 0; k < T; k++) begin
            send_tick(24'h0, 24'h7FFFFF);
            wait_result($sformatf("satp%0d", k), 1, model_out(0), model_out(1));
        end
        check("sat_pos", bus_if.audio1_out, 24'h7FFFFF);
        for (int k = 0; k < T; k++) begin
            send_tick(24'h0, 24'h800000);
            wait_result($sformatf("satn%0d", k), 1, model_out(0), model_out(1));
        end
        check("sat_neg", bus_if.audio1_out, 24'h800000);

        // Overrun: second tick 3 cycles after the first is dropped.
        set_coefs_zero();
        coef[0] = 32'h00400000;
        coef[1] = 32'h00200000;
        apply_regs();
        pulse_clr();
        v0 = valid_seen;
        o0 = ovr_seen;
        send_tick(24'h100000, 24'h0);
        step(2);
        bus_if.audio0_in = 24'h300000;
        bus_if.tick_in   = 1'b1;
        @(negedge clk);
        bus_if.tick_in = 1'b0;
        check("ovr_pulse", bus_if.overrun_out, 1'b1);
        wait_result("ovr_first", 4, model_out(0), model_out(1));
        check("ovr_count", ovr_seen - o0, 1);
        check("ovr_valid_count", valid_seen - v0, 1);
        send_tick(24'h040000, 24'h0);
        wait_result("ovr_next", 1, model_out(0), model_out(1));
        check("hist_once", bus_if.audio0_out, 24'h060000);

        // Clear during MAC1.
        coef[T] = 32'h00400000;
        apply_regs();
        send_tick(24'h200000, 24'h100000);
        step(T + 1);
        v0 = valid_seen;
        bus_if.clr_in = 1'b1;
        @(negedge clk);
        bus_if.clr_in = 1'b0;
        model_clear();
        check("clr_busy", bus_if.busy_out, 1'b0);
        check("clr_out0", bus_if.audio0_out, 24'h0);
        check("clr_out1", bus_if.audio1_out, 24'h0);
        step(LAT + 2);
        check("clr_novalid", valid_seen - v0, 0);
        send_tick(24'h100000, 24'h080000);
        wait_result("after_clr", 1, model_out(0), model_out(1));
        check("after_clr_const", bus_if.audio1_out, 24'h040000);

        // Clear and tick together.
        v0 = valid_seen;
        o0 = ovr_seen;
        bus_if.clr_in    = 1'b1;
        bus_if.tick_in   = 1'b1;
        bus_if.audio0_in = 24'h123456;
        @(negedge clk);
        bus_if.clr_in  = 1'b0;
        bus_if.tick_in = 1'b0;
        model_clear();
        check("clrtick_busy", bus_if.busy_out, 1'b0);
        step(LAT + 2);
        check("clrtick_novalid", valid_seen - v0, 0);
        check("clrtick_noovr", ovr_seen - o0, 0);

        // Reset during MAC0.
        send_tick(24'h100000, 24'h100000);
        wait_result("pre_rst", 1, model_out(0), model_out(1));
        send_tick(24'h300000, 24'h200000);
        step(1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_out0", bus_if.audio0_out, 24'h0);
        check("mrst_out1", bus_if.audio1_out, 24'h0);
        check("mrst_valid", bus_if.valid_out, 1'b0);
        check("mrst_busy", bus_if.busy_out, 1'b0);
        check("mrst_overrun", bus_if.overrun_out, 1'b0);
        rst = 1'b0;
        model_clear();
        v0 = valid_seen;
        step(LAT + 2);
        check("mrst_novalid", valid_seen - v0, 0);
        send_tick(24'h080000, 24'h100000);
        wait_result("after_rst", 1, model_out(0), model_out(1));

        // Randomized traffic with play-low ticks and play falling mid-sequence.
        for (int r = 0; r < 30; r++) begin
            if ((r % 5) == 0) begin
                for (int i = 0; i < DSP_REGISTERS; i++) coef[i] = $urandom;
                apply_regs();
            end
            gap = int'($urandom_range(0, 3));
            step(gap);
            if ($urandom_range(0, 3) == 0) begin
                v0 = valid_seen;
                bus_if.play_in = 1'b0;
                send_tick(24'(($urandom)), 24'($urandom));
                check("play_low_busy", bus_if.busy_out, 1'b0);
                check("play_low_ovr", bus_if.overrun_out, 1'b0);
                bus_if.play_in = 1'b1;
            end
            ra0 = 24'($urandom);
            ra1 = 24'($urandom);
            send_tick(ra0, ra1);
            if ($urandom_range(0, 2) == 0) bus_if.play_in = 1'b0;
            wait_result($sformatf("rnd%0d", r), 1, model_out(0), model_out(1));
            bus_if.play_in = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
